// File: rtl/diff_window_stats.sv
// Windowed statistics over the subtractor's signed difference stream:
// per WIN_LEN accepted samples, emits sum, min, max and non-negative count.
module diff_window_stats #(
  parameter int unsigned WIN_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  diff,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] sum,
  output logic [8:0]  min,
  output logic [8:0]  max,
  output logic [8:0]  nonneg_cnt
);

  localparam int unsigned IDX_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned SUM_W = 17;
  localparam int unsigned D_W   = 9;
  localparam int unsigned CNT_W = 9;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic signed [D_W-1:0]   acc_min_q, acc_min_d;
  logic signed [D_W-1:0]   acc_max_q, acc_max_d;
  logic [CNT_W-1:0]        acc_nn_q, acc_nn_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [D_W-1:0]   min_q, min_d;
  logic signed [D_W-1:0]   max_q, max_d;
  logic [CNT_W-1:0]        nn_q, nn_d;

  logic                    accept;
  logic                    first;
  logic                    last;
  logic signed [D_W-1:0]   diff_s;
  logic signed [SUM_W-1:0] nxt_sum;
  logic signed [D_W-1:0]   nxt_min;
  logic signed [D_W-1:0]   nxt_max;
  logic [CNT_W-1:0]        nxt_nn;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last) state_d = HOLD;
      HOLD:    if (out_ready)      state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs decoded from registered state only (clr aborts acceptance)
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM:   in_ready  = !clr && rst_n;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulator datapath; first sample of a window seeds min/max directly
  always_comb begin
    diff_s  = $signed(diff);
    accept  = in_valid && in_ready;
    first   = (idx_q == '0);
    last    = (idx_q == IDX_W'(WIN_LEN - 1));
    nxt_sum = acc_sum_q + SUM_W'(diff_s);
    nxt_min = (first || (diff_s < acc_min_q)) ? diff_s : acc_min_q;
    nxt_max = (first || (diff_s > acc_max_q)) ? diff_s : acc_max_q;
    nxt_nn  = acc_nn_q + CNT_W'(!diff[8]);

    idx_d     = idx_q;
    acc_sum_d = acc_sum_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    acc_nn_d  = acc_nn_q;
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    nn_d      = nn_q;

    if (state_q == ACCUM) begin
      if (clr || (accept && last)) begin
        idx_d     = '0;
        acc_sum_d = '0;
        acc_min_d = '0;
        acc_max_d = '0;
        acc_nn_d  = '0;
      end else if (accept) begin
        idx_d     = idx_q + IDX_W'(1);
        acc_sum_d = nxt_sum;
        acc_min_d = nxt_min;
        acc_max_d = nxt_max;
        acc_nn_d  = nxt_nn;
      end
      if (accept && last) begin
        sum_d = nxt_sum;
        min_d = nxt_min;
        max_d = nxt_max;
        nn_d  = nxt_nn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      acc_sum_q <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
      acc_nn_q  <= '0;
      sum_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      nn_q      <= '0;
    end else begin
      idx_q     <= idx_d;
      acc_sum_q <= acc_sum_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      acc_nn_q  <= acc_nn_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      nn_q      <= nn_d;
    end
  end

  assign sum        = sum_q;
  assign min        = min_q;
  assign max        = max_q;
  assign nonneg_cnt = nn_q;

endmodule

// File: tb/tb_diff_window_stats.sv
// Bench for diff_window_stats: cycle model + result scoreboard on a WIN_LEN=4
// instance, plus a WIN_LEN=256 instance for the sum/count extremes.
module tb_diff_window_stats;

  typedef struct {
    logic signed [16:0] s;
    logic signed [8:0]  mn;
    logic signed [8:0]  mx;
    logic [8:0]         nn;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIN_LEN=4 instance
  logic               clr, in_valid, out_ready;
  logic [8:0]         diff;
  logic               in_ready, out_valid;
  logic signed [16:0] sum4;
  logic signed [8:0]  mn4, mx4;
  logic [8:0]         nn4;

  // WIN_LEN=256 instance
  logic               b_clr, b_in_valid, b_out_ready;
  logic [8:0]         b_diff;
  logic               b_in_ready, b_out_valid;
  logic signed [16:0] b_sum;
  logic signed [8:0]  b_mn, b_mx;
  logic [8:0]         b_nn;

  diff_window_stats #(.WIN_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .out_valid(out_valid), .out_ready(out_ready), .sum(sum4),
    .min(mn4), .max(mx4), .nonneg_cnt(nn4)
  );

  diff_window_stats #(.WIN_LEN(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .diff(b_diff), .out_valid(b_out_valid), .out_ready(b_out_ready), .sum(b_sum),
    .min(b_mn), .max(b_mx), .nonneg_cnt(b_nn)
  );

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  res_t m_out;
  bit   m_hold;
  int   m_idx, m_sum, m_min, m_max, m_nn;

  task automatic chk(input string tag, input logic signed [16:0] obs,
                     input logic signed [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_idx = 0; m_sum = 0; m_min = 0; m_max = 0; m_nn = 0;
  endtask

  // One cycle on the WIN_LEN=4 instance; entered and left 1 time unit after a rising edge
  task automatic step(input bit v, input int d, input bit c, input bit ordy);
    res_t e;
    in_valid = v; diff = 9'(d); clr = c; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !m_hold && !c);
    chk("out_valid", out_valid, m_hold);
    chk("sum_stable", sum4, m_out.s);
    chk("min_stable", mn4, m_out.mn);
    chk("max_stable", mx4, m_out.mx);
    chk("nn_stable", nn4, m_out.nn);
    if (m_hold && ordy) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 17'(q.size()), 17'sd1);
      end else begin
        e = q.pop_front();
        chk("hs_sum", sum4, e.s);
        chk("hs_min", mn4, e.mx < e.mn ? e.mx : e.mn);
        chk("hs_max", mx4, e.mx);
        chk("hs_nn", nn4, e.nn);
      end
    end
    @(posedge clk);
    if (!m_hold) begin
      if (c) model_clear();
      else if (v) begin
        if (m_idx == 0) begin m_min = d; m_max = d; end
        else begin
          if (d < m_min) m_min = d;
          if (d > m_max) m_max = d;
        end
        m_sum += d;
        if (d >= 0) m_nn++;
        if (m_idx == 3) begin
          e.s = 17'(m_sum); e.mn = 9'(m_min); e.mx = 9'(m_max); e.nn = 9'(m_nn);
          q.push_back(e);
          m_out  = e;
          m_hold = 1'b1;
          model_clear();
        end else m_idx++;
      end
    end else if (ordy) m_hold = 1'b0;
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum4, 17'sd0);
    chk("rst_min", mn4, 17'sd0);
    chk("rst_max", mx4, 17'sd0);
    chk("rst_nn", nn4, 17'sd0);
    m_hold = 1'b0;
    m_out  = '{17'sd0, 9'sd0, 9'sd0, 9'd0};
    q.delete();
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  bit all_ready;

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; diff = '0;
    b_clr = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_diff = '0;
    m_hold = 1'b0;
    m_out  = '{17'sd0, 9'sd0, 9'sd0, 9'd0};
    model_clear();
    #2;
    chk("init_in_ready", in_ready, 1'b0);
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_sum", sum4, 17'sd0);
    chk("init_b_out_valid", b_out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic window: +10 -5 +255 -255
    step(1, 10, 0, 1); step(1, -5, 0, 1); step(1, 255, 0, 1); step(1, -255, 0, 1);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_sum", sum4, 17'sd5);
    chk("t1_min", mn4, -17'sd255);
    chk("t1_max", mx4, 17'sd255);
    chk("t1_nn", nn4, 17'sd2);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Backpressure: results held 5 cycles while input keeps offering
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 99, 0, 0);
    step(1, 99, 0, 1);
    step(1, 5, 0, 1); step(1, 6, 0, 1); step(1, -7, 0, 1); step(1, 8, 0, 1);
    chk("bp_sum", sum4, 17'sd12);
    chk("bp_min", mn4, -17'sd7);
    step(0, 0, 0, 1);

    // Gapped input: 0, 3, -1, 7 with in_valid toggling
    step(1, 0, 0, 1); step(0, 50, 0, 1); step(1, 3, 0, 1); step(0, 50, 0, 1);
    step(1, -1, 0, 1); step(0, 50, 0, 1); step(1, 7, 0, 1);
    chk("gap_sum", sum4, 17'sd9);
    chk("gap_min", mn4, -17'sd1);
    chk("gap_max", mx4, 17'sd7);
    chk("gap_nn", nn4, 17'sd3);
    step(0, 0, 0, 1);

    // clr mid-window discards partial accumulation and the sample offered with it
    step(1, -100, 0, 1); step(1, -100, 0, 1); step(1, 50, 1, 1);
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    chk("clr_sum", sum4, 17'sd4);
    chk("clr_min", mn4, 17'sd1);
    chk("clr_max", mx4, 17'sd1);
    chk("clr_nn", nn4, 17'sd4);
    step(1, 9, 1, 1);
    step(0, 0, 0, 1);

    // Reset mid-window, then a fresh window
    step(1, 30, 0, 1); step(1, -40, 0, 1);
    async_reset();
    step(1, 2, 0, 1); step(1, 2, 0, 1); step(1, 2, 0, 1); step(1, 2, 0, 1);
    chk("rst_win_sum", sum4, 17'sd8);
    step(0, 0, 0, 1);

    // Reset while holding a result
    step(1, -3, 0, 0); step(1, -3, 0, 0); step(1, -3, 0, 0); step(1, 6, 0, 0);
    step(0, 0, 0, 0);
    async_reset();
    step(1, 2, 0, 1); step(1, 2, 0, 1); step(1, 2, 0, 1); step(1, 2, 0, 1);
    chk("rst_hold_sum", sum4, 17'sd8);
    chk("rst_hold_nn", nn4, 17'sd4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("sb_drained", 17'(q.size()), 17'sd0);

    // WIN_LEN=256 extremes
    in_valid = 1'b0;
    all_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b_in_valid = 1'b1; b_diff = 9'h101; b_out_ready = 1'b0;
      #1;
      if (b_in_ready !== 1'b1) all_ready = 1'b0;
      @(posedge clk); #1;
    end
    chk("ext_neg_ready", all_ready, 1'b1);
    chk("ext_neg_valid", b_out_valid, 1'b1);
    chk("ext_neg_sum", b_sum, -17'sd65280);
    chk("ext_neg_min", b_mn, -17'sd255);
    chk("ext_neg_max", b_mx, -17'sd255);
    chk("ext_neg_nn", b_nn, 17'sd0);
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ext_hs_valid", b_out_valid, 1'b0);
    for (int i = 0; i < 256; i++) begin
      b_in_valid = 1'b1; b_diff = 9'd255; b_out_ready = 1'b0;
      @(posedge clk); #1;
    end
    chk("ext_pos_valid", b_out_valid, 1'b1);
    chk("ext_pos_sum", b_sum, 17'sd65280);
    chk("ext_pos_min", b_mn, 17'sd255);
    chk("ext_pos_max", b_mx, 17'sd255);
    chk("ext_pos_nn", b_nn, 17'sd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/diff_window_stats.md
# diff_window_stats

Downstream consumer of the 8-bit subtractor stage. It accepts the subtractor's 9-bit two's-complement difference (a − b, range −255..+255) over a valid/ready handshake. For each window of WIN_LEN accepted samples it accumulates the signed sum, minimum, maximum and count of non-negative samples. At the end of each window it presents the registered results on a second valid/ready handshake to the next stage (logger or monitor).

## Interface

- WIN_LEN, default 16: samples per window; legal range 2..256; any integer, not restricted to powers of two.
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort: discards the partial window.
- in_valid  input  1  diff is valid.
- in_ready  output  1  block accepts a sample this cycle.
- diff  input  9  signed difference from the subtractor stage (two's complement).
- out_valid  output  1  window results valid.
- out_ready  input  1  downstream accepts results.
- sum  output  17  signed sum of the window's samples.
- min  output  9  signed minimum sample.
- max  output  9  signed maximum sample.
- nonneg_cnt  output  9  count of samples with diff ≥ 0 (0..256).

## Operation

- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- A sample is accepted when in_valid && in_ready at a rising edge.
- Accumulation in ACCUM:
  - acc_sum += sign-extended diff (17-bit signed).
  - acc_min and acc_max update with signed compare.
  - acc_nn increments if diff[8]==0.
  - idx increments.
- The first sample of a window loads acc_min and acc_max directly. There are no sentinel values.
- ACCUM→HOLD on acceptance of sample number WIN_LEN, i.e. idx==WIN_LEN−1 at acceptance:
  - the final values, including that last sample, load into sum/min/max/nonneg_cnt;
  - the accumulators and idx clear.
- HOLD→ACCUM when out_valid && out_ready. While in HOLD:
  - outputs hold stable;
  - no samples are accepted.
- clr=1:
  - in ACCUM: clears the accumulators and idx; any sample offered that cycle is discarded (in_ready is forced 0 that cycle).
  - in HOLD: no effect. The pending result is still delivered.
- in_valid gaps do not affect accumulation. Only accepted samples count.
- Width rules: worst-case |sum| = 255×256 = 65280, which fits in 17-bit signed. The sum never wraps.
- Reset (rst_n=0, asynchronous, at any point including mid-window or in HOLD):
  - state=ACCUM;
  - in_ready=0 while rst_n=0;
  - out_valid=0, sum=0, min=0, max=0, nonneg_cnt=0;
  - accumulators and idx = 0.

## Timing

- in_ready is registered-state decoded: in_ready = (state==ACCUM) && !clr && rst_n. It has no combinational path from in_valid or out_ready.
- Latency: the last sample is accepted at edge k. Then out_valid=1 and the results are valid after edge k.
- Output handshake at edge m: out_valid=0 and in_ready=1 after edge m. The first sample of the next window is accepted no earlier than edge m+1.
- Throughput: one sample per cycle in ACCUM, plus one bubble cycle per window for the output transfer at the earliest.
- Back-to-back: with out_ready held 1, a window of N samples plus HOLD takes N+1 cycles minimum.
- Outputs are all registered. sum/min/max/nonneg_cnt change only on the ACCUM→HOLD transition or on reset.

## Test plan

- WIN_LEN=4, diffs +10, −5, +255, −255 back-to-back, out_ready=1 → one cycle after the 4th acceptance: out_valid=1, sum=+5, min=−255, max=+255, nonneg_cnt=2. out_valid falls the following cycle.
- Backpressure: after a window completes, hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout, outputs stable. Raise out_ready → handshake, then in_ready=1 the next cycle, and no samples are lost or double-counted.
- Gapped input, WIN_LEN=4: diffs 0, 3, −1, 7 with in_valid toggling 1,0,1,0,… → sum=+9, min=−1, max=+7, nonneg_cnt=3. Results are identical to the no-gap run.
- clr mid-window: accept −100, −100, pulse clr, then accept 1, 1, 1, 1 → sum=+4, min=max=+1, nonneg_cnt=4. The sample offered during the clr cycle sees in_ready=0.
- Reset mid-window and in HOLD: assert rst_n=0 asynchronously between edges → all outputs 0 immediately. After release, a fresh window of 4×(+2) → sum=+8.
- Extremes, WIN_LEN=256: all samples −255 → sum=−65280 (17'h10100), min=max=−255, nonneg_cnt=0. Then all samples +255 → sum=+65280, nonneg_cnt=256.
